// File: rtl/ex_hazard_forward_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ex_hazard_forward_ctrl_pkg
//   Shared definitions for the EX-stage hazard/forwarding controller:
//   forward-select encoding, FSM state encoding and the default register-index
//   width.
// ----------------------------------------------------------------------------
package ex_hazard_forward_ctrl_pkg;

   // Default register-index width (32 architectural registers).
   localparam int REG_AW_DFLT = 5;

   // EX operand-mux select. 2'b11 is never produced.
   typedef logic [1:0] fwd_sel_t;
   localparam fwd_sel_t FWD_RF  = 2'b00;  // register file / immediate
   localparam fwd_sel_t FWD_WB  = 2'b01;  // WB Write_data
   localparam fwd_sel_t FWD_MEM = 2'b10;  // MEM rd_data

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

endpackage

// File: rtl/ex_hazard_forward_ctrl_if.sv
// ----------------------------------------------------------------------------
// ex_hazard_forward_ctrl_if
//   Bundle between the ID stage / pipeline control and the hazard controller.
//   master : ID-side instruction tags and pipeline events (drives id_*,
//            ext_hold, flush_req; receives selects and stall controls)
//   slave  : the controller itself
// ----------------------------------------------------------------------------
interface ex_hazard_forward_ctrl_if
   import ex_hazard_forward_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DFLT,
   parameter int CNT_W  = 32
);
   // ID-stage instruction tags
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_mem_read;
   // Pipeline events
   logic              ext_hold;
   logic              flush_req;
   // Controller outputs
   fwd_sel_t          ForwardA;
   fwd_sel_t          ForwardB;
   logic              pc_write;
   logic              if_id_write;
   logic              ex_bubble;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_reg_write, id_mem_read, ext_hold, flush_req,
      input  ForwardA, ForwardB, pc_write, if_id_write, ex_bubble, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_reg_write, id_mem_read, ext_hold, flush_req,
      output ForwardA, ForwardB, pc_write, if_id_write, ex_bubble, stall_cnt
   );

endinterface

// File: rtl/ex_hazard_forward_ctrl_fwd_sel_logic.sv
// ----------------------------------------------------------------------------
// fwd_sel_logic
//   Pure combinational forward-select for one source operand of the
//   instruction in ID.
//   Ports:
//     src, use_src            source index and "operand is read" flag
//     ex_valid/reg_write/rd   tags of the instruction currently in EX
//     mem_valid/reg_write/rd  tags of the instruction currently in MEM
//     sel                     select to apply when this instruction reaches EX
// ----------------------------------------------------------------------------
module fwd_sel_logic
   import ex_hazard_forward_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DFLT
) (
   input  logic [REG_AW-1:0] src,
   input  logic              use_src,
   input  logic              ex_valid,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   output fwd_sel_t          sel
);

   // The EX producer is one stage closer, so it holds the newer value and
   // wins over the MEM producer. The WB producer needs no path because the
   // register file is write-first.
   always_comb begin
      // NOTE: assign a default first so every path drives sel and no latch is inferred.
      sel = FWD_RF;
      if (src != '0 && use_src) begin
         if (ex_valid && ex_reg_write && ex_rd == src) begin
            sel = FWD_MEM;
         end else if (mem_valid && mem_reg_write && mem_rd == src) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/ex_hazard_forward_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_forward_ctrl
//   EX-stage forwarding and stall controller. Tracks destination tags of the
//   instructions in EX and MEM, registers ForwardA/ForwardB so they line up
//   with the instruction's EX cycle, and inserts a single bubble on a
//   load-use hazard.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   ex_hazard_forward_ctrl_if.slave (ID tags, hold/flush in;
//           ForwardA/B, pc_write, if_id_write, ex_bubble, stall_cnt out)
// ----------------------------------------------------------------------------
module ex_hazard_forward_ctrl
   import ex_hazard_forward_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DFLT,
   parameter int CNT_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   ex_hazard_forward_ctrl_if.slave   bus
);

   // Tag pipeline. A WB copy is not kept: the register file is write-first,
   // so nothing downstream of MEM ever influences a select or a stall.
   logic              ex_valid, ex_reg_write, ex_mem_read;
   logic [REG_AW-1:0] ex_rd;
   logic              mem_valid, mem_reg_write;
   logic [REG_AW-1:0] mem_rd;

   state_t            state;
   fwd_sel_t          fwd_a_q, fwd_b_q;
   fwd_sel_t          sel_a, sel_b;
   logic [CNT_W-1:0]  cnt_q;

   logic              load_use;
   logic              squash;

   fwd_sel_logic #(.REG_AW(REG_AW)) u_sel_a (
      .src           (bus.id_rs1),
      .use_src       (bus.id_use_rs1),
      .ex_valid      (ex_valid),
      .ex_reg_write  (ex_reg_write),
      .ex_rd         (ex_rd),
      .mem_valid     (mem_valid),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .sel           (sel_a)
   );

   fwd_sel_logic #(.REG_AW(REG_AW)) u_sel_b (
      .src           (bus.id_rs2),
      .use_src       (bus.id_use_rs2),
      .ex_valid      (ex_valid),
      .ex_reg_write  (ex_reg_write),
      .ex_rd         (ex_rd),
      .mem_valid     (mem_valid),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .sel           (sel_b)
   );

   // A load in EX delivers its data only at the end of MEM, one cycle too
   // late for a dependent instruction entering EX next.
   always_comb begin
      load_use = bus.id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                 ((bus.id_use_rs1 && bus.id_rs1 == ex_rd) ||
                  (bus.id_use_rs2 && bus.id_rs2 == ex_rd));
      // Either event replaces the ID instruction in ID/EX with a NOP.
      squash   = bus.flush_req || load_use;
   end

   // Stall controls are combinational so the bubble and the PC/IF-ID hold
   // take effect in the same cycle the hazard is seen.
   always_comb begin
      bus.pc_write    = 1'b1;
      bus.if_id_write = 1'b1;
      bus.ex_bubble   = 1'b0;
      if (bus.ext_hold) begin
         bus.pc_write    = 1'b0;
         bus.if_id_write = 1'b0;
      end else if (bus.flush_req) begin
         bus.ex_bubble   = 1'b1;
      end else if (load_use) begin
         bus.pc_write    = 1'b0;
         bus.if_id_write = 1'b0;
         bus.ex_bubble   = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_RUN;
         ex_valid      <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_rd         <= '0;
         mem_valid     <= 1'b0;
         mem_reg_write <= 1'b0;
         mem_rd        <= '0;
         fwd_a_q       <= FWD_RF;
         fwd_b_q       <= FWD_RF;
         cnt_q         <= '0;
      end else if (!bus.ext_hold) begin
         mem_valid     <= ex_valid;
         mem_reg_write <= ex_reg_write;
         mem_rd        <= ex_rd;
         ex_valid      <= bus.id_valid && !squash;
         ex_reg_write  <= bus.id_reg_write;
         ex_mem_read   <= bus.id_mem_read;
         ex_rd         <= bus.id_rd;
         fwd_a_q       <= squash ? FWD_RF : sel_a;
         fwd_b_q       <= squash ? FWD_RF : sel_b;

         if (load_use && !bus.flush_req && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end

         // STALL lasts one cycle: the bubble now sits in EX, so the load is in
         // MEM and the re-evaluated ID instruction resolves to a WB forward.
         case (state)
            ST_RUN:   state <= (load_use && !bus.flush_req) ? ST_STALL : ST_RUN;
            ST_STALL: state <= ST_RUN;
            default:  state <= ST_RUN;
         endcase
      end
   end

   assign bus.ForwardA  = fwd_a_q;
   assign bus.ForwardB  = fwd_b_q;
   assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_ex_hazard_forward_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_hazard_forward_ctrl
//   Drives instruction streams into the controller, predicts every cycle's
//   outputs with an independent reference model, and compares them through a
//   scoreboard queue. Scenario tasks add targeted checks of their own.
// ----------------------------------------------------------------------------
module tb_ex_hazard_forward_ctrl;

   localparam int AW = 5;
   localparam int CW = 4;  // narrow counter so saturation is reachable

   typedef struct packed {
      logic          pc_write;
      logic          if_id_write;
      logic          ex_bubble;
      logic [1:0]    fa;
      logic [1:0]    fb;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb_q[$];

   // Reference model state
   logic          m_ex_v, m_ex_rw, m_ex_mr;
   logic [AW-1:0] m_ex_rd;
   logic          m_mem_v, m_mem_rw;
   logic [AW-1:0] m_mem_rd;
   logic [1:0]    m_fa, m_fb;
   logic [CW-1:0] m_cnt;

   ex_hazard_forward_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

   ex_hazard_forward_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [1:0] ref_sel(input logic [AW-1:0] s, input logic u);
      if (s == 0 || !u) return 2'b00;
      if (m_ex_v && m_ex_rw && m_ex_rd == s) return 2'b10;
      if (m_mem_v && m_mem_rw && m_mem_rd == s) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_ex_v = 0; m_ex_rw = 0; m_ex_mr = 0; m_ex_rd = '0;
      m_mem_v = 0; m_mem_rw = 0; m_mem_rd = '0;
      m_fa = 2'b00; m_fb = 2'b00; m_cnt = '0;
   endtask

   // One clock of stimulus: predicts this cycle's outputs, queues them, then
   // advances the model to what the next edge will capture.
   task automatic drive(input logic r, input logic v,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2,
                        input logic [AW-1:0] rd, input logic rw, input logic mr,
                        input logic hold, input logic flush);
      exp_t       e;
      logic       lu;
      logic [1:0] na, nb;
      @(posedge clk);
      #2;
      rst              = r;
      bus.id_valid     = v;
      bus.id_rs1       = rs1;
      bus.id_rs2       = rs2;
      bus.id_use_rs1   = u1;
      bus.id_use_rs2   = u2;
      bus.id_rd        = rd;
      bus.id_reg_write = rw;
      bus.id_mem_read  = mr;
      bus.ext_hold     = hold;
      bus.flush_req    = flush;

      lu = v && m_ex_v && m_ex_mr && (m_ex_rd != 0) &&
           ((u1 && rs1 == m_ex_rd) || (u2 && rs2 == m_ex_rd));
      e.pc_write    = hold ? 1'b0 : (flush ? 1'b1 : !lu);
      e.if_id_write = e.pc_write;
      e.ex_bubble   = !hold && (flush || lu);
      e.fa          = m_fa;
      e.fb          = m_fb;
      e.cnt         = m_cnt;
      sb_q.push_back(e);

      if (r) begin
         model_reset();
      end else if (!hold) begin
         na = (flush || lu) ? 2'b00 : ref_sel(rs1, u1);
         nb = (flush || lu) ? 2'b00 : ref_sel(rs2, u2);
         m_fa = na;
         m_fb = nb;
         if (lu && !flush && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
         m_mem_v  = m_ex_v;
         m_mem_rw = m_ex_rw;
         m_mem_rd = m_ex_rd;
         m_ex_v   = v && !(flush || lu);
         m_ex_rw  = rw;
         m_ex_mr  = mr;
         m_ex_rd  = rd;
      end
   endtask

   task automatic op_alu(input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2);
      drive(1'b0, 1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic op_load(input logic [AW-1:0] rd, input logic [AW-1:0] rs1);
      drive(1'b0, 1'b1, rs1, '0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic op_nop();
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Scoreboard: one expected entry per driven cycle, compared mid-cycle.
   initial begin
      forever begin
         exp_t e;
         @(negedge clk);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({bus.pc_write, bus.if_id_write, bus.ex_bubble} !==
                {e.pc_write, e.if_id_write, e.ex_bubble}) begin
               errors++;
               $display("FAIL sb_ctrl t=%0t pc/ifid/bubble got=%b%b%b exp=%b%b%b", $time,
                        bus.pc_write, bus.if_id_write, bus.ex_bubble,
                        e.pc_write, e.if_id_write, e.ex_bubble);
            end
            checks++;
            if ({bus.ForwardA, bus.ForwardB} !== {e.fa, e.fb}) begin
               errors++;
               $display("FAIL sb_fwd t=%0t A/B got=%b/%b exp=%b/%b", $time,
                        bus.ForwardA, bus.ForwardB, e.fa, e.fb);
            end
            checks++;
            if (bus.stall_cnt !== e.cnt) begin
               errors++;
               $display("FAIL sb_cnt t=%0t got=%0d exp=%0d", $time, bus.stall_cnt, e.cnt);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0;
      bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_rd = '0;
      bus.id_reg_write = 0; bus.id_mem_read = 0;
      bus.ext_hold = 0; bus.flush_req = 0;
      repeat (2) @(posedge clk);
      settle();
      model_reset();
      checks++;
      if ({bus.pc_write, bus.if_id_write, bus.ex_bubble} !== 3'b110) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=110", {bus.pc_write, bus.if_id_write, bus.ex_bubble});
      end
      checks++;
      if ({bus.ForwardA, bus.ForwardB} !== 4'b0000 || bus.stall_cnt !== '0) begin
         errors++;
         $display("FAIL reset_regs fwd=%b%b cnt=%0d exp fwd=0000 cnt=0",
                  bus.ForwardA, bus.ForwardB, bus.stall_cnt);
      end
   endtask

   task automatic test_fwd_mem();
      op_alu(5'd5, 5'd1, 5'd2);       // add x5,x1,x2
      op_alu(5'd6, 5'd5, 5'd1);       // add x6,x5,x1
      op_nop();
      settle();
      checks++;
      if (bus.ForwardA !== 2'b10 || bus.ForwardB !== 2'b00) begin
         errors++;
         $display("FAIL fwd_mem A/B got=%b/%b exp=10/00", bus.ForwardA, bus.ForwardB);
      end
      checks++;
      if (bus.stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL fwd_mem_cnt got=%0d exp=0", bus.stall_cnt);
      end
   endtask

   task automatic test_fwd_wb_x0();
      op_alu(5'd5, 5'd1, 5'd2);       // add x5
      op_nop();
      op_alu(5'd7, 5'd1, 5'd5);       // sub x7,x1,x5
      op_nop();
      settle();
      checks++;
      if (bus.ForwardA !== 2'b00 || bus.ForwardB !== 2'b01) begin
         errors++;
         $display("FAIL fwd_wb A/B got=%b/%b exp=00/01", bus.ForwardA, bus.ForwardB);
      end
      op_alu(5'd0, 5'd1, 5'd2);       // writes x0
      op_alu(5'd8, 5'd0, 5'd0);       // reads x0 twice
      op_nop();
      settle();
      checks++;
      if (bus.ForwardA !== 2'b00 || bus.ForwardB !== 2'b00) begin
         errors++;
         $display("FAIL fwd_x0 A/B got=%b/%b exp=00/00", bus.ForwardA, bus.ForwardB);
      end
   endtask

   task automatic test_load_use();
      op_load(5'd5, 5'd1);            // lw x5
      op_alu(5'd6, 5'd5, 5'd5);       // add x6,x5,x5
      settle();
      checks++;
      if ({bus.pc_write, bus.if_id_write, bus.ex_bubble} !== 3'b001) begin
         errors++;
         $display("FAIL load_use_stall got=%b exp=001",
                  {bus.pc_write, bus.if_id_write, bus.ex_bubble});
      end
      op_alu(5'd6, 5'd5, 5'd5);       // held in ID, re-evaluated
      settle();
      checks++;
      if ({bus.pc_write, bus.if_id_write, bus.ex_bubble} !== 3'b110) begin
         errors++;
         $display("FAIL load_use_release got=%b exp=110",
                  {bus.pc_write, bus.if_id_write, bus.ex_bubble});
      end
      op_nop();
      settle();
      checks++;
      if (bus.ForwardA !== 2'b01 || bus.ForwardB !== 2'b01 || bus.stall_cnt !== 4'd1) begin
         errors++;
         $display("FAIL load_use_fwd A/B=%b/%b cnt=%0d exp 01/01 cnt=1",
                  bus.ForwardA, bus.ForwardB, bus.stall_cnt);
      end
   endtask

   task automatic test_flush();
      op_load(5'd5, 5'd1);
      drive(1'b0, 1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
      settle();
      checks++;
      if ({bus.pc_write, bus.if_id_write, bus.ex_bubble} !== 3'b111) begin
         errors++;
         $display("FAIL flush_ctrl got=%b exp=111",
                  {bus.pc_write, bus.if_id_write, bus.ex_bubble});
      end
      op_nop();
      settle();
      checks++;
      if (bus.stall_cnt !== 4'd1 || bus.ForwardA !== 2'b00) begin
         errors++;
         $display("FAIL flush_after cnt=%0d A=%b exp cnt=1 A=00", bus.stall_cnt, bus.ForwardA);
      end
   endtask

   task automatic test_hold_in_stall();
      op_load(5'd5, 5'd1);
      op_alu(5'd6, 5'd5, 5'd3);       // stall cycle
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
         settle();
         checks++;
         if ({bus.pc_write, bus.if_id_write, bus.ex_bubble} !== 3'b000 ||
             bus.ForwardA !== 2'b00 || bus.stall_cnt !== 4'd2) begin
            errors++;
            $display("FAIL hold_frozen[%0d] ctrl=%b A=%b cnt=%0d exp ctrl=000 A=00 cnt=2", i,
                     {bus.pc_write, bus.if_id_write, bus.ex_bubble}, bus.ForwardA, bus.stall_cnt);
         end
      end
      op_alu(5'd6, 5'd5, 5'd3);
      op_nop();
      settle();
      checks++;
      if (bus.ForwardA !== 2'b01 || bus.ForwardB !== 2'b00 || bus.stall_cnt !== 4'd2) begin
         errors++;
         $display("FAIL hold_release A/B=%b/%b cnt=%0d exp 01/00 cnt=2",
                  bus.ForwardA, bus.ForwardB, bus.stall_cnt);
      end
   endtask

   task automatic test_reset_in_stall();
      op_load(5'd5, 5'd1);
      op_alu(5'd6, 5'd5, 5'd5);       // stall, counter -> 3
      drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      op_alu(5'd6, 5'd5, 5'd5);
      settle();
      checks++;
      if ({bus.pc_write, bus.if_id_write, bus.ex_bubble} !== 3'b110 ||
          {bus.ForwardA, bus.ForwardB} !== 4'b0000 || bus.stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_in_stall ctrl=%b fwd=%b%b cnt=%0d exp ctrl=110 fwd=0000 cnt=0",
                  {bus.pc_write, bus.if_id_write, bus.ex_bubble},
                  bus.ForwardA, bus.ForwardB, bus.stall_cnt);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 15; i++) begin
         op_load(5'd9, 5'd1);
         op_alu(5'd10, 5'd2, 5'd9);
         op_alu(5'd10, 5'd2, 5'd9);
      end
      settle();
      checks++;
      if (bus.stall_cnt !== 4'hF) begin
         errors++;
         $display("FAIL sat_reach got=%0d exp=15", bus.stall_cnt);
      end
      for (int i = 0; i < 2; i++) begin
         op_load(5'd9, 5'd1);
         op_alu(5'd10, 5'd9, 5'd2);
         op_alu(5'd10, 5'd9, 5'd2);
      end
      op_nop();
      settle();
      checks++;
      if (bus.stall_cnt !== 4'hF) begin
         errors++;
         $display("FAIL sat_hold got=%0d exp=15", bus.stall_cnt);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fwd_mem();
      test_fwd_wb_x0();
      test_load_use();
      test_flush();
      test_hold_in_stall();
      test_reset_in_stall();
      test_saturation();
      op_nop();
      settle();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain left=%0d exp=0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
